// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package regfile_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int CNTW = $clog2(NREG + 1);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [CNTW-1:0] busy_cnt_t;

  function automatic busy_cnt_t popcount(input logic [NREG-1:0] v);
    busy_cnt_t c;
    c = '0;
    for (int k = 0; k < NREG; k++) c = c + busy_cnt_t'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read, write and issue-claim bundle between issue/writeback logic and the register file.
interface regfile_mp_sb_if #(
  parameter int NRD = 2,
  parameter int NWR = 2
);
  import regfile_pkg::*;

  reg_addr_t [NRD-1:0] ra;
  word_t     [NRD-1:0] rd;
  logic      [NRD-1:0] rbusy;
  logic      [NWR-1:0] we;
  reg_addr_t [NWR-1:0] wa;
  word_t     [NWR-1:0] wd;
  logic                issue_valid;
  reg_addr_t           issue_rd;
  logic                issue_ready;
  busy_cnt_t           nbusy;

  modport master (
    output ra, we, wa, wd, issue_valid, issue_rd,
    input  rd, rbusy, issue_ready, nbusy
  );

  modport slave (
    input  ra, we, wa, wd, issue_valid, issue_rd,
    output rd, rbusy, issue_ready, nbusy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracking: claim sets, writeback clears, claim wins on a tie.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  reg_addr_t [NRD-1:0] ra,
  input  logic      [NWR-1:0] we,
  input  reg_addr_t [NWR-1:0] wa,
  input  logic                issue_valid,
  input  reg_addr_t           issue_rd,
  output logic      [NRD-1:0] rbusy,
  output logic                issue_ready,
  output busy_cnt_t           nbusy
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wr_hit;
  busy_cnt_t       nbusy_q, nbusy_d;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NWR; i++) begin
      if (we[i]) wr_hit[wa[i]] = 1'b1;
    end
  end

  // A writeback in the same cycle resolves the hazard for readers and claimers.
  always_comb begin
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      rbusy[j] = busy_q[ra[j]] & ~wr_hit[ra[j]];
    end
    issue_ready = (issue_rd == '0) | ~busy_q[issue_rd] | wr_hit[issue_rd];
  end

  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (issue_valid && issue_ready && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    nbusy_d   = popcount(busy_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign nbusy = nbusy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// NRD-read / NWR-write integer register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input logic            clk,
  input logic            reset_n,
  regfile_mp_sb_if.slave bus
);

  word_t rf_q [NREG];
  word_t rf_d [NREG];
  word_t [NRD-1:0] rd_v;

  // Ascending port order makes the highest-index writer win on address collisions.
  always_comb begin
    rf_d = rf_q;
    for (int i = 0; i < NWR; i++) begin
      if (bus.we[i] && (bus.wa[i] != '0)) rf_d[bus.wa[i]] = bus.wd[i];
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rd_v = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_v[j] = rf_q[bus.ra[j]];
      for (int i = 0; i < NWR; i++) begin
        if (bus.we[i] && (bus.wa[i] == bus.ra[j]) && (bus.ra[j] != '0)) rd_v[j] = bus.wd[i];
      end
    end
  end

  assign bus.rd = rd_v;

  reg_scoreboard #(
    .NRD(NRD),
    .NWR(NWR)
  ) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .ra         (bus.ra),
    .we         (bus.we),
    .wa         (bus.wa),
    .issue_valid(bus.issue_valid),
    .issue_rd   (bus.issue_rd),
    .rbusy      (bus.rbusy),
    .issue_ready(bus.issue_ready),
    .nbusy      (bus.nbusy)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic vs. a reference model.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  regfile_mp_sb_if #(.NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp_sb #(.NRD(NRD), .NWR(NWR)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t m_rf   [NREG];
  bit    m_busy [NREG];

  function automatic bit written(input reg_addr_t a);
    for (int i = 0; i < NWR; i++) if (bus.we[i] && bus.wa[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic word_t exp_rd(input int j);
    word_t v;
    v = m_rf[bus.ra[j]];
    for (int i = 0; i < NWR; i++)
      if (bus.we[i] && bus.wa[i] == bus.ra[j] && bus.ra[j] != 0) v = bus.wd[i];
    return v;
  endfunction

  function automatic bit exp_rbusy(input int j);
    return m_busy[bus.ra[j]] && !written(bus.ra[j]);
  endfunction

  function automatic bit exp_ready();
    return (bus.issue_rd == 0) || !m_busy[bus.issue_rd] || written(bus.issue_rd);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < NREG; k++) c += int'(m_busy[k]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) begin
      m_rf[k]   = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.ra = '0; bus.we = '0; bus.wa = '0; bus.wd = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
  endtask

  // Apply the architectural effect of the current inputs, then advance one clock.
  task automatic cycle();
    bit rdy;
    rdy = exp_ready();
    for (int i = 0; i < NWR; i++) if (bus.we[i] && bus.wa[i] != 0) m_rf[bus.wa[i]] = bus.wd[i];
    for (int i = 0; i < NWR; i++) if (bus.we[i]) m_busy[bus.wa[i]] = 1'b0;
    if (bus.issue_valid && rdy && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    word_t v;
    v = {$urandom, $urandom} | 64'h1;
    idle();
    bus.we[0] = 1'b1; bus.wa[0] = 5'd5; bus.wd[0] = v;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    cycle();
    idle();
    bus.ra[0] = 5'd5; bus.issue_rd = 5'd6;
    #1;
    n_tests++;
    if (bus.rd[0] !== v) begin n_fail++; $display("FAIL pre_reset_rd: got %h expected %h", bus.rd[0], v); end
    n_tests++;
    if (bus.nbusy !== 6'd1) begin n_fail++; $display("FAIL pre_reset_nbusy: got %0d expected 1", bus.nbusy); end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.rd !== '0) begin n_fail++; $display("FAIL in_reset_rd: got %h expected 0", bus.rd); end
    n_tests++;
    if (bus.rbusy !== 2'b00 || bus.nbusy !== 6'd0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_reset_sb: rbusy=%b nbusy=%0d ready=%b expected 00/0/1", bus.rbusy, bus.nbusy, bus.issue_ready);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    n_tests++;
    if (bus.rd[0] !== '0 || bus.rd[1] !== '0 || bus.rbusy !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_read: rd0=%h rd1=%h rbusy=%b expected 0/0/00", bus.rd[0], bus.rd[1], bus.rbusy);
    end
    n_tests++;
    if (bus.nbusy !== 6'd0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_sb: nbusy=%0d ready=%b expected 0/1", bus.nbusy, bus.issue_ready);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.we[0] = 1'b1; bus.wa[0] = 5'd5; bus.wd[0] = 64'hDEAD_BEEF_0000_0001; bus.ra[0] = 5'd5;
    @(negedge clk);
    n_tests++;
    if (bus.rd[0] !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL bypass_rd: got %h expected deadbeef00000001", bus.rd[0]); end
    cycle();
    idle();
    bus.ra[0] = 5'd5;
    @(negedge clk);
    n_tests++;
    if (bus.rd[0] !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL stored_rd: got %h expected deadbeef00000001", bus.rd[0]); end
  endtask

  task automatic test_priority();
    idle();
    bus.we = 2'b11; bus.wa[0] = 5'd7; bus.wa[1] = 5'd7; bus.wd[0] = 64'd1; bus.wd[1] = 64'd2; bus.ra[1] = 5'd7;
    @(negedge clk);
    n_tests++;
    if (bus.rd[1] !== 64'd2) begin n_fail++; $display("FAIL prio_bypass: got %h expected 2", bus.rd[1]); end
    cycle();
    idle();
    bus.ra[0] = 5'd7;
    @(negedge clk);
    n_tests++;
    if (bus.rd[0] !== 64'd2) begin n_fail++; $display("FAIL prio_stored: got %h expected 2", bus.rd[0]); end
  endtask

  task automatic test_reg0();
    int n0;
    idle();
    bus.we[0] = 1'b1; bus.wa[0] = 5'd0; bus.wd[0] = 64'hFF; bus.ra[1] = 5'd0;
    @(negedge clk);
    n_tests++;
    if (bus.rd[1] !== '0) begin n_fail++; $display("FAIL r0_no_bypass: got %h expected 0", bus.rd[1]); end
    cycle();
    idle();
    bus.ra[0] = 5'd0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    n0 = m_count();
    @(negedge clk);
    n_tests++;
    if (bus.rd[0] !== '0 || bus.rbusy[0] !== 1'b0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_read_claim: rd=%h rbusy=%b ready=%b expected 0/0/1", bus.rd[0], bus.rbusy[0], bus.issue_ready);
    end
    cycle();
    n_tests++;
    if (int'(bus.nbusy) != n0) begin n_fail++; $display("FAIL r0_nbusy: got %0d expected %0d", bus.nbusy, n0); end
  endtask

  task automatic test_raw_waw();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    @(negedge clk);
    n_tests++;
    if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL claim3_ready: got %b expected 1", bus.issue_ready); end
    cycle();
    bus.ra[0] = 5'd3;
    @(negedge clk);
    n_tests++;
    if (bus.rbusy[0] !== 1'b1 || bus.nbusy !== 6'd1) begin
      n_fail++;
      $display("FAIL raw_busy: rbusy=%b nbusy=%0d expected 1/1", bus.rbusy[0], bus.nbusy);
    end
    n_tests++;
    if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b expected 0", bus.issue_ready); end
    cycle();
    n_tests++;
    if (bus.nbusy !== 6'd1) begin n_fail++; $display("FAIL waw_nbusy: got %0d expected 1", bus.nbusy); end
    bus.we[0] = 1'b1; bus.wa[0] = 5'd3; bus.wd[0] = 64'h33;
    @(negedge clk);
    n_tests++;
    if (bus.issue_ready !== 1'b1 || bus.rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_resolve: ready=%b rbusy=%b expected 1/0", bus.issue_ready, bus.rbusy[0]);
    end
    cycle();
    idle();
    bus.ra[0] = 5'd3;
    @(negedge clk);
    n_tests++;
    if (bus.nbusy !== 6'd1 || bus.rbusy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: nbusy=%0d rbusy=%b expected 1/1", bus.nbusy, bus.rbusy[0]);
    end
    bus.we[1] = 1'b1; bus.wa[1] = 5'd3; bus.wd[1] = 64'h34;
    cycle();
    n_tests++;
    if (bus.nbusy !== 6'd0) begin n_fail++; $display("FAIL clear3: got %0d expected 0", bus.nbusy); end
  endtask

  task automatic test_claim_clear();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cycle();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    bus.we[1] = 1'b1; bus.wa[1] = 5'd9; bus.wd[1] = 64'h99;
    cycle();
    idle();
    bus.ra[0] = 5'd4; bus.ra[1] = 5'd9;
    @(negedge clk);
    n_tests++;
    if (bus.nbusy !== 6'd1) begin n_fail++; $display("FAIL swap_nbusy: got %0d expected 1", bus.nbusy); end
    n_tests++;
    if (bus.rbusy !== 2'b01) begin n_fail++; $display("FAIL swap_rbusy: got %b expected 01", bus.rbusy); end
    bus.we[0] = 1'b1; bus.wa[0] = 5'd4;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < NRD; j++) bus.ra[j] = reg_addr_t'($urandom_range(0, 7));
      for (int i = 0; i < NWR; i++) begin
        bus.we[i] = ($urandom_range(0, 2) == 0);
        bus.wa[i] = reg_addr_t'($urandom_range(0, 7));
        bus.wd[i] = {$urandom, $urandom};
      end
      bus.issue_valid = $urandom_range(0, 1) == 1;
      bus.issue_rd = ($urandom_range(0, 9) == 0) ? reg_addr_t'($urandom) : reg_addr_t'($urandom_range(0, 7));
      @(negedge clk);
      for (int j = 0; j < NRD; j++) begin
        n_tests++;
        if (bus.rd[j] !== exp_rd(j)) begin n_fail++; $display("FAIL rnd_rd%0d cyc %0d: got %h expected %h", j, c, bus.rd[j], exp_rd(j)); end
        n_tests++;
        if (bus.rbusy[j] !== exp_rbusy(j)) begin n_fail++; $display("FAIL rnd_rbusy%0d cyc %0d: got %b expected %b", j, c, bus.rbusy[j], exp_rbusy(j)); end
      end
      n_tests++;
      if (bus.issue_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", c, bus.issue_ready, exp_ready()); end
      cycle();
      n_tests++;
      if (int'(bus.nbusy) != m_count() || int'(bus.nbusy) > NREG - 1) begin
        n_fail++;
        $display("FAIL rnd_nbusy cyc %0d: got %0d expected %0d", c, bus.nbusy, m_count());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    test_reset();
    test_bypass();
    test_priority();
    test_reg0();
    test_raw_waw();
    test_claim_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with a built-in busy-bit scoreboard, for the next-generation 64-bit core datapath.
- Generalises the current 2R/1W register file to NRD read ports and NWR write ports.
- Adds write-to-read bypass and per-register pending-write tracking, so issue logic can detect RAW and WAW hazards without a separate unit.
- Sits between decode/issue and the execute/writeback stages.

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- AW, $clog2(NREG), address width (derived; not overridden).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  read addresses; port j uses ra[j].
- rd  out  NRD*XLEN  read data, combinational.
- rbusy  out  NRD  register at ra[j] has a pending write not being resolved this cycle.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- issue_valid  in  1  issue stage requests to claim destination issue_rd.
- issue_rd  in  AW  destination register being claimed.
- issue_ready  out  1  claim is accepted this cycle.
- nbusy  out  $clog2(NREG+1)  count of registers currently marked busy.

Behaviour:
- Reset: asynchronous and active-low; one clock; clock and reset are clk and reset_n.
  - reset_n low immediately clears all registers to 0, all busy bits to 0 and nbusy to 0.
  - Consequently rd=0, rbusy=0 and issue_ready=1 while reset is asserted.
  - Reset asserted mid-operation discards in-flight writes and claims; there is no recovery.
- Register 0:
  - Writes to register 0 are ignored.
  - Reads of register 0 return 0 with rbusy=0.
  - Claims on register 0 are always accepted but set nothing.
- Write:
  - At the rising edge, for each i with we[i]=1 and wa[i]!=0, rf[wa[i]] <= wd[i].
  - If two ports write the same address in one cycle, the highest-index port wins.
- Read (zero latency):
  - rd[j] returns rf[ra[j]], except when some port i has we[i]=1 and wa[i]==ra[j]!=0 in the same cycle.
  - In that case rd[j]=wd[i] from the highest-index matching port (bypass).
- Scoreboard:
  - One busy bit per register.
  - A write to a register clears its busy bit at the edge.
  - An accepted claim sets busy[issue_rd] at the edge.
  - If a claim and a write hit the same register in the same cycle, the set wins: the new producer is in flight.
- rbusy[j] = busy[ra[j]] AND NOT (any we[i] with wa[i]==ra[j]); i.e. the writeback resolves the RAW hazard in the same cycle.
- issue_ready:
  - High when busy[issue_rd]=0, when issue_rd is being written this cycle, or when issue_rd==0.
  - Low otherwise (WAW stall).
  - issue_valid with issue_ready low has no effect; the issuer holds the request.
- nbusy:
  - Registered popcount of the busy vector, updated every edge to reflect the next-state busy bits.
  - Never exceeds NREG-1.
- A write to a non-busy register is legal: data is written and busy stays 0.

Decomposition:
- Package regfile_pkg holds:
  - constants XLEN=64 and NREG=32;
  - typedef word_t (logic [XLEN-1:0]);
  - typedef reg_addr_t (logic [$clog2(NREG)-1:0]).
- One natural sub-module, reg_scoreboard, owns:
  - the busy vector;
  - claim/clear priority;
  - issue_ready, rbusy and the nbusy counter.
- The top level keeps the storage array and the bypass muxing.

Test Plan:
- Reset then read: assert reset_n=0 mid-run, release, read ra={5,0} -> rd={0,0}, rbusy=0, nbusy=0, issue_ready=1.
- Bypass: we[0]=1, wa[0]=5, wd[0]=64'hDEAD_BEEF_0000_0001, ra[0]=5 in same cycle -> rd[0]=64'hDEAD_BEEF_0000_0001 combinationally; next cycle with we=0, rd[0] holds it.
- Port priority: we={1,1}, wa={7,7}, wd[0]=1, wd[1]=2 -> bypass and stored value are both 2.
- Register 0: we[0]=1, wa[0]=0, wd[0]=64'hFF -> subsequent read of register 0 is 0; claim of register 0 accepted with nbusy unchanged.
- RAW/WAW sequence:
  - Claim register 3 -> next cycle rbusy for ra=3 is 1, nbusy=1.
  - A second claim of register 3 gives issue_ready=0 and nbusy stays 1.
  - A write to register 3 gives issue_ready=1 and rbusy=0 that cycle; if the claim is held, busy stays set and nbusy=1.
- Claim/clear on different registers: claim register 4 while writing busy register 9 -> nbusy is unchanged overall, busy[4]=1, busy[9]=0.
